// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback commit buffer and the ID-stage stall logic
// that must agree with it on register address width and buffer depth.
package wb_commit_pkg;

    localparam int WB_REG_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH     = 64;
    localparam int WB_PC_WIDTH       = 64;
    localparam int WB_DEPTH          = 4;

    // Count width used by every block that observes buffer occupancy
    function automatic int wb_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_commit_chk.sv
// Occupancy checker for wb_commit: the buffer count must never exceed its depth.
module wb_commit_chk #(
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH))
        else $error("wb_commit count overflow: %0d", count);

endmodule

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of pending register writes, exposing the head entry
// and a per-slot {valid, waddr} view for pending-write comparisons.
module wb_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 64,
    parameter int PW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic [PW-1:0]           pc_i,
    output logic [AW-1:0]           head_waddr_o,
    output logic [DW-1:0]           head_wdata_o,
    output logic [PW-1:0]           head_pc_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [DEPTH-1:0]        ent_valid_o,
    output logic [DEPTH*AW-1:0]     ent_waddr_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [AW-1:0]   waddr_q [DEPTH];
    logic [DW-1:0]   wdata_q [DEPTH];
    logic [PW-1:0]   pc_q    [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTRW{1'b0}};
            rd_ptr_d = {PTRW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and entry storage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTRW{1'b0}};
            rd_ptr_q <= {PTRW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= {AW{1'b0}};
                wdata_q[i] <= {DW{1'b0}};
                pc_q[i]    <= {PW{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                waddr_q[wr_ptr_q] <= waddr_i;
                wdata_q[wr_ptr_q] <= wdata_i;
                pc_q[wr_ptr_q]    <= pc_i;
            end
        end
    end

    // Slot i is live when its distance from the head is below the occupancy
    always_comb begin
        logic [PTRW-1:0] offset;
        offset      = {PTRW{1'b0}};
        ent_valid_o = {DEPTH{1'b0}};
        ent_waddr_o = {(DEPTH*AW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offset               = PTRW'(i) - rd_ptr_q;
            ent_valid_o[i]       = ({1'b0, offset} < count_q);
            ent_waddr_o[i*AW +: AW] = waddr_q[i];
        end
    end

    assign head_waddr_o = waddr_q[rd_ptr_q];
    assign head_wdata_o = wdata_q[rd_ptr_q];
    assign head_pc_o    = pc_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback commit buffer: queues EX/MEM results, drains one per cycle into the
// register file through a registered commit stage, and flags pending writes to ID.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int DEPTH          = WB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_ADDR_WIDTH-1:0]   in_waddr,
    input  logic [DATA_WIDTH-1:0]       in_wdata,
    input  logic [63:0]                 in_pc,
    input  logic                        flush,
    input  logic                        rf_busy,
    output logic                        reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]   reg_waddr,
    output logic [DATA_WIDTH-1:0]       reg_wdata,
    output logic [63:0]                 commit_pc,
    output logic                        write_ready,
    input  logic [REG_ADDR_WIDTH-1:0]   reg1_raddr,
    input  logic [REG_ADDR_WIDTH-1:0]   reg2_raddr,
    output logic                        pend1,
    output logic                        pend2,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = REG_ADDR_WIDTH;
    localparam int CW = wb_count_width(DEPTH);

    logic [CW-1:0]         count_s;
    logic                  push_s;
    logic                  pop_s;
    logic [AW-1:0]         head_waddr_s;
    logic [DATA_WIDTH-1:0] head_wdata_s;
    logic [63:0]           head_pc_s;
    logic [DEPTH-1:0]      ent_valid_s;
    logic [DEPTH*AW-1:0]   ent_waddr_s;
    logic                  hit1_s;
    logic                  hit2_s;

    logic                  write_ready_q, write_ready_d;
    logic                  reg_wen_q,     reg_wen_d;
    logic [AW-1:0]         reg_waddr_q,   reg_waddr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q,   reg_wdata_d;
    logic [63:0]           commit_pc_q,   commit_pc_d;

    // No bypass: readiness looks only at registered occupancy, never at this cycle's pop
    assign in_ready = !rst && !flush && (count_s < CW'(DEPTH));
    assign push_s   = in_valid && in_ready;
    assign pop_s    = (count_s != {CW{1'b0}}) && !rf_busy && !flush;

    wb_fifo #(
        .AW    (AW),
        .DW    (DATA_WIDTH),
        .PW    (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .flush_i      (flush),
        .waddr_i      (in_waddr),
        .wdata_i      (in_wdata),
        .pc_i         (in_pc),
        .head_waddr_o (head_waddr_s),
        .head_wdata_o (head_wdata_s),
        .head_pc_o    (head_pc_s),
        .count_o      (count_s),
        .ent_valid_o  (ent_valid_s),
        .ent_waddr_o  (ent_waddr_s)
    );

    // Commit stage next-state; x0 entries still pulse write_ready but never enable the write
    always_comb begin
        write_ready_d = pop_s;
        reg_wen_d     = pop_s && (head_waddr_s != {AW{1'b0}});
        reg_waddr_d   = reg_waddr_q;
        reg_wdata_d   = reg_wdata_q;
        commit_pc_d   = commit_pc_q;
        if (pop_s) begin
            reg_waddr_d = head_waddr_s;
            reg_wdata_d = head_wdata_s;
            commit_pc_d = head_pc_s;
        end else begin
            reg_waddr_d = reg_waddr_q;
            reg_wdata_d = reg_wdata_q;
            commit_pc_d = commit_pc_q;
        end
    end

    // Commit stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            write_ready_q <= 1'b0;
            reg_wen_q     <= 1'b0;
            reg_waddr_q   <= {AW{1'b0}};
            reg_wdata_q   <= {DATA_WIDTH{1'b0}};
            commit_pc_q   <= 64'h0;
        end else begin
            write_ready_q <= write_ready_d;
            reg_wen_q     <= reg_wen_d;
            reg_waddr_q   <= reg_waddr_d;
            reg_wdata_q   <= reg_wdata_d;
            commit_pc_q   <= commit_pc_d;
        end
    end

    // Pending compare across live FIFO slots plus the commit stage while it is writing
    always_comb begin
        hit1_s = write_ready_q && (reg_waddr_q == reg1_raddr);
        hit2_s = write_ready_q && (reg_waddr_q == reg2_raddr);
        for (int i = 0; i < DEPTH; i++) begin
            hit1_s = hit1_s | (ent_valid_s[i] && (ent_waddr_s[i*AW +: AW] == reg1_raddr));
            hit2_s = hit2_s | (ent_valid_s[i] && (ent_waddr_s[i*AW +: AW] == reg2_raddr));
        end
    end

    assign pend1       = hit1_s && (reg1_raddr != {AW{1'b0}});
    assign pend2       = hit2_s && (reg2_raddr != {AW{1'b0}});
    assign write_ready = write_ready_q;
    assign reg_wen     = reg_wen_q;
    assign reg_waddr   = reg_waddr_q;
    assign reg_wdata   = reg_wdata_q;
    assign commit_pc   = commit_pc_q;
    assign count       = count_s;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: reset, a per-cycle vector table, and a scoreboarded
// stream with random register-file back-pressure.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_waddr = 5'd0;
    logic [63:0] in_wdata = 64'h0;
    logic [63:0] in_pc = 64'h0;
    logic        flush = 1'b0;
    logic        rf_busy = 1'b0;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic [63:0] commit_pc;
    logic        write_ready;
    logic [4:0]  reg1_raddr = 5'd0;
    logic [4:0]  reg2_raddr = 5'd0;
    logic        pend1;
    logic        pend2;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_commit #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_waddr(in_waddr), .in_wdata(in_wdata), .in_pc(in_pc), .flush(flush),
        .rf_busy(rf_busy), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .commit_pc(commit_pc), .write_ready(write_ready),
        .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr), .pend1(pend1),
        .pend2(pend2), .count(count)
    );

    wb_commit_chk #(.DEPTH(4)) u_chk (.clk(clk), .rst(rst), .count(count));

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [63:0] d;
        logic [63:0] pc;
        logic        busy;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  cnt;
        logic        rdy;
        logic        wr;
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [63:0] cpc;
        logic        p1;
        logic        p2;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
        logic [63:0] pc;
        int          idx;
    } ent_t;

    vec_t vq[$];
    ent_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] a, input logic [63:0] d,
                       input logic [63:0] pc, input logic busy, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [2:0] cnt, input logic rdy, input logic wr,
                       input logic wen, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [63:0] cpc, input logic p1, input logic p2);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.pc = pc; t.busy = busy; t.fl = fl;
        t.r1 = r1; t.r2 = r2; t.cnt = cnt; t.rdy = rdy; t.wr = wr; t.wen = wen;
        t.wa = wa; t.wd = wd; t.cpc = cpc; t.p1 = p1; t.p2 = p2;
        vq.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, mcnt;
        logic exp_pop, exp_push;
        ent_t popped, e;

        // single write, then x0 write
        add(1, 5,  64'hDEAD_BEEF, 64'h100, 0, 0, 5, 0,  1, 1, 0, 0, 0, 64'h0,         64'h0,   1, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 5, 0,  0, 1, 1, 1, 5, 64'hDEAD_BEEF, 64'h100, 1, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 5, 0,  0, 1, 0, 0, 5, 64'hDEAD_BEEF, 64'h100, 0, 0);
        add(1, 0,  64'h11,        64'h104, 0, 0, 0, 5,  1, 1, 0, 0, 5, 64'hDEAD_BEEF, 64'h100, 0, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 0, 0,  0, 1, 1, 0, 0, 64'h11,        64'h104, 0, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 0, 0,  0, 1, 0, 0, 0, 64'h11,        64'h104, 0, 0);
        // fill under rf_busy, fifth rejected, then drain in order
        add(1, 1,  64'hA1,        64'h200, 1, 0, 4, 5,  1, 1, 0, 0, 0, 64'h11,        64'h104, 0, 0);
        add(1, 2,  64'hA2,        64'h204, 1, 0, 4, 5,  2, 1, 0, 0, 0, 64'h11,        64'h104, 0, 0);
        add(1, 3,  64'hA3,        64'h208, 1, 0, 4, 5,  3, 1, 0, 0, 0, 64'h11,        64'h104, 0, 0);
        add(1, 4,  64'hA4,        64'h20C, 1, 0, 4, 5,  4, 0, 0, 0, 0, 64'h11,        64'h104, 1, 0);
        add(1, 5,  64'hA5,        64'h210, 1, 0, 4, 5,  4, 0, 0, 0, 0, 64'h11,        64'h104, 1, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 1, 4,  3, 1, 1, 1, 1, 64'hA1,        64'h200, 1, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 1, 4,  2, 1, 1, 1, 2, 64'hA2,        64'h204, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 1, 4,  1, 1, 1, 1, 3, 64'hA3,        64'h208, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 1, 4,  0, 1, 1, 1, 4, 64'hA4,        64'h20C, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 1, 4,  0, 1, 0, 0, 4, 64'hA4,        64'h20C, 0, 0);
        // flush with entry 1 in the commit stage; in_valid ignored during flush
        add(1, 7,  64'hB7,        64'h300, 1, 0, 8, 9,  1, 1, 0, 0, 4, 64'hA4,        64'h20C, 0, 0);
        add(1, 8,  64'hB8,        64'h304, 1, 0, 8, 9,  2, 1, 0, 0, 4, 64'hA4,        64'h20C, 1, 0);
        add(1, 9,  64'hB9,        64'h308, 1, 0, 8, 9,  3, 1, 0, 0, 4, 64'hA4,        64'h20C, 1, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 8, 9,  2, 1, 1, 1, 7, 64'hB7,        64'h300, 1, 1);
        add(1, 10, 64'hC0,        64'h400, 0, 1, 8, 10, 0, 0, 0, 0, 7, 64'hB7,        64'h300, 0, 0);
        add(0, 0,  64'h0,         64'h0,   0, 0, 8, 10, 0, 1, 0, 0, 7, 64'hB7,        64'h300, 0, 0);
        // enqueue and pop on the same edge
        add(1, 11, 64'hD1,        64'h500, 0, 0, 11, 0, 1, 1, 0, 0, 7, 64'hB7,        64'h300, 1, 0);
        add(1, 12, 64'hD2,        64'h504, 0, 0, 11, 12, 1, 1, 1, 1, 11, 64'hD1,      64'h500, 1, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 11, 12, 0, 1, 1, 1, 12, 64'hD2,      64'h504, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 11, 12, 0, 1, 0, 0, 12, 64'hD2,      64'h504, 0, 0);
        // full FIFO pops but does not accept on the same edge
        add(1, 13, 64'hE1,        64'h600, 1, 0, 17, 16, 1, 1, 0, 0, 12, 64'hD2,      64'h504, 0, 0);
        add(1, 14, 64'hE2,        64'h604, 1, 0, 17, 16, 2, 1, 0, 0, 12, 64'hD2,      64'h504, 0, 0);
        add(1, 15, 64'hE3,        64'h608, 1, 0, 17, 16, 3, 1, 0, 0, 12, 64'hD2,      64'h504, 0, 0);
        add(1, 16, 64'hE4,        64'h60C, 1, 0, 17, 16, 4, 0, 0, 0, 12, 64'hD2,      64'h504, 0, 1);
        add(1, 17, 64'hE5,        64'h610, 0, 0, 17, 16, 3, 1, 1, 1, 13, 64'hE1,      64'h600, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 17, 16, 2, 1, 1, 1, 14, 64'hE2,      64'h604, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 17, 16, 1, 1, 1, 1, 15, 64'hE3,      64'h608, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 17, 16, 0, 1, 1, 1, 16, 64'hE4,      64'h60C, 0, 1);
        add(0, 0,  64'h0,         64'h0,   0, 0, 17, 16, 0, 1, 0, 0, 16, 64'hE4,      64'h60C, 0, 0);

        // reset held 3 cycles with in_valid high
        rst = 1'b1; in_valid = 1'b1; in_waddr = 5'd3; in_wdata = 64'h55; in_pc = 64'h80;
        reg1_raddr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d count", i), 64'(count), 64'h0);
            check($sformatf("rst%0d in_ready", i), 64'(in_ready), 64'h0);
            check($sformatf("rst%0d reg_wen", i), 64'(reg_wen), 64'h0);
            check($sformatf("rst%0d write_ready", i), 64'(write_ready), 64'h0);
            check($sformatf("rst%0d reg_waddr", i), 64'(reg_waddr), 64'h0);
            check($sformatf("rst%0d reg_wdata", i), reg_wdata, 64'h0);
            check($sformatf("rst%0d commit_pc", i), commit_pc, 64'h0);
            check($sformatf("rst%0d pend1", i), 64'(pend1), 64'h0);
        end
        rst = 1'b0; in_valid = 1'b0; reg1_raddr = 5'd0;
        @(posedge clk); #1;
        check("post_rst count", 64'(count), 64'h0);
        check("post_rst in_ready", 64'(in_ready), 64'h1);
        check("post_rst write_ready", 64'(write_ready), 64'h0);

        foreach (vq[n]) begin
            in_valid = vq[n].v; in_waddr = vq[n].a; in_wdata = vq[n].d; in_pc = vq[n].pc;
            rf_busy = vq[n].busy; flush = vq[n].fl;
            reg1_raddr = vq[n].r1; reg2_raddr = vq[n].r2;
            @(posedge clk); #1;
            check($sformatf("v%0d count", n), 64'(count), 64'(vq[n].cnt));
            check($sformatf("v%0d in_ready", n), 64'(in_ready), 64'(vq[n].rdy));
            check($sformatf("v%0d write_ready", n), 64'(write_ready), 64'(vq[n].wr));
            check($sformatf("v%0d reg_wen", n), 64'(reg_wen), 64'(vq[n].wen));
            check($sformatf("v%0d reg_waddr", n), 64'(reg_waddr), 64'(vq[n].wa));
            check($sformatf("v%0d reg_wdata", n), reg_wdata, vq[n].wd);
            check($sformatf("v%0d commit_pc", n), commit_pc, vq[n].cpc);
            check($sformatf("v%0d pend1", n), 64'(pend1), 64'(vq[n].p1));
            check($sformatf("v%0d pend2", n), 64'(pend2), 64'(vq[n].p2));
        end

        // 20-write stream with random back-pressure, checked against a count/order model
        flush = 1'b0; reg1_raddr = 5'd0; reg2_raddr = 5'd0;
        sent = 0; got = 0; mcnt = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            in_valid = (sent < 20);
            in_waddr = 5'((sent % 31) + 1);
            in_wdata = 64'h1111 * 64'(sent + 1);
            in_pc    = 64'h1000 + 64'(4 * sent);
            rf_busy  = 1'($urandom_range(0, 1));
            exp_pop  = (mcnt != 0) && !rf_busy;
            exp_push = in_valid && (mcnt < 4);
            if (exp_pop) begin
                popped = sb.pop_front();
                mcnt--;
            end
            if (exp_push) begin
                e.a = in_waddr; e.d = in_wdata; e.pc = in_pc; e.idx = sent;
                sb.push_back(e);
                sent++;
                mcnt++;
            end
            @(posedge clk); #1;
            check("stream count", 64'(count), 64'(mcnt));
            check("stream write_ready", 64'(write_ready), 64'(exp_pop));
            if (exp_pop) begin
                check("stream order", 64'(popped.idx), 64'(got));
                check("stream reg_waddr", 64'(reg_waddr), 64'(popped.a));
                check("stream reg_wdata", reg_wdata, popped.d);
                check("stream commit_pc", commit_pc, popped.pc);
                check("stream reg_wen", 64'(reg_wen), 64'h1);
                got++;
            end
        end
        in_valid = 1'b0; rf_busy = 1'b0;
        check("stream commits", 64'(got), 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit buffer between EX/MEM and the integer register file. It accepts completed results over a valid/ready handshake, holds them in a small in-order FIFO, and drains one entry per cycle into the register-file write port. It drives `write_ready`, the commit pulse the ID-stage hazard logic waits on. It also answers pending-write queries for the two ID source registers, so ID can stall exactly until the matching write has landed.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register address width (matches `rvseed_defines`)
- `DATA_WIDTH`, 64, register data width
- `DEPTH`, 4, FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  EX/MEM result valid
- `in_ready`  out  1  buffer can accept this cycle
- `in_waddr`  in  REG_ADDR_WIDTH  destination register
- `in_wdata`  in  DATA_WIDTH  result data
- `in_pc`  in  64  PC of the producing instruction (debug/trace)
- `flush`  in  1  drop all uncommitted FIFO entries
- `rf_busy`  in  1  register-file port unavailable; hold the drain
- `reg_wen`  out  1  register-file write enable
- `reg_waddr`  out  REG_ADDR_WIDTH  register-file write address
- `reg_wdata`  out  DATA_WIDTH  register-file write data
- `commit_pc`  out  64  PC of the entry being committed
- `write_ready`  out  1  one-cycle commit pulse
- `reg1_raddr`  in  REG_ADDR_WIDTH  ID source 1 query
- `reg2_raddr`  in  REG_ADDR_WIDTH  ID source 2 query
- `pend1`  out  1  write to `reg1_raddr` is outstanding
- `pend2`  out  1  write to `reg2_raddr` is outstanding
- `count`  out  $clog2(DEPTH)+1  valid FIFO entries

## Operation
- **Reset.** All outputs are 0 after reset. The FIFO is empty, pointers are 0, and `count` is 0. Reset overrides every other input in the same cycle.
- **Enqueue.**
  - `in_ready = !rst && !flush && (count < DEPTH)`.
  - An entry `{waddr, wdata, pc}` is written at the tail on an edge where `in_valid && in_ready`.
- **Drain.**
  - Pop condition: `count != 0 && !rf_busy && !flush`.
  - On a pop, the head entry loads the registered commit stage.
  - In the following cycle, `write_ready` is 1 and `commit_pc` holds the popped PC.
  - In that same cycle, `reg_wen` is 1 unless `waddr == 0`. For x0 entries, `reg_wen` stays 0 but `write_ready` still pulses.
  - Outside commit cycles, `reg_wen` and `write_ready` are 0. `reg_waddr`, `reg_wdata` and `commit_pc` hold their last values.
- **Simultaneous events.**
  - Enqueue and pop on the same edge: `count` is unchanged and both pointers advance.
  - No bypass: a full FIFO does not accept data on the same edge it pops.
- **Flush.**
  - The FIFO is emptied on the edge and `count` becomes 0.
  - A commit already in the output stage still completes.
  - `in_valid` is ignored while `flush` is high.
- **Pending query.**
  - `pendN` is combinational. It is 1 when `regN_raddr != 0` and any of these targets it:
    - a valid FIFO entry, or
    - the output stage while `write_ready` is 1.
  - This means ID stalls until the cycle after `write_ready`. It can then read the register file, which is write-before-read.
- **Pointers.** Pointers wrap modulo `DEPTH`. `count` saturates only by construction and must never exceed `DEPTH`; an overflow is an assertion failure.

## Timing
- Accept-to-commit latency on an empty FIFO with `rf_busy = 0`:
  - accept on edge E0,
  - pop on E1,
  - `reg_wen`/`write_ready` high in the cycle after E1.
- Throughput is one commit per cycle while the FIFO is non-empty and `rf_busy` is low.
- `rf_busy` high freezes the head entry. Commits resume on the first edge after `rf_busy` falls.
- `in_ready` depends only on registered `count` plus `flush`/`rst`. It has no combinational path from `in_valid`.
- `pend1`/`pend2` are combinational from `regN_raddr` and registered state. They add no cycles.

## Structure
- `REG_ADDR_WIDTH` comes from `rvseed_defines.v`.
- Add `WB_DEPTH` to the same shared defines file so ID stall logic and this block agree on depth.
- Sub-module `wb_fifo` is a parameterised synchronous FIFO with `push`, `pop`, `flush`, `count`, a head read port, and a flat per-entry `{valid, waddr}` vector for the pending compare.
- The top level holds:
  - the commit stage register,
  - the x0 suppression,
  - the two pending comparators.

## Test plan
- **Reset.** Hold `rst` 3 cycles with `in_valid = 1` → all outputs 0, `count` = 0, no entry enqueued.
- **Single write.** Enqueue `waddr = 5`, `wdata = 0xDEAD_BEEF` with `reg1_raddr = 5` → `pend1 = 1` for 2 cycles. `reg_wen`, `write_ready` and `reg_waddr = 5` are high in cycle 2. `pend1 = 0` in cycle 3.
- **Fill and stall.**
  - With `rf_busy = 1`, enqueue 5 back-to-back → 4 accepted, `in_ready = 0`, `count = 4`.
  - Release `rf_busy` → 4 commits on consecutive cycles, in order.
- **x0 write.** Enqueue `waddr = 0` → `write_ready` pulses, `reg_wen` stays 0, and `pend1` stays 0 with `reg1_raddr = 0`.
- **Flush mid-drain.** With 3 entries queued and entry 1 in the commit stage, assert `flush` → entry 1 still commits, the rest are dropped, and `count = 0`.
- **Wrap-around.** Stream 20 writes with random `rf_busy` → commit order matches enqueue order and the `count` invariant holds throughout.
